// File: rtl/sha_pio_bridge_if.sv
// CPU PIO port group and shared hash-core register bus used by sha_pio_bridge.
interface sha_pio_bridge_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0]        pio_write;
    logic [ADDR_W-1:0]        pio_address;
    logic [7:0]               pio_control;
    logic [DATA_W-1:0]        pio_read;
    logic [7:0]               pio_status;
    logic [NUM_CH-1:0]        core_cs;
    logic [NUM_CH-1:0]        core_we;
    logic [ADDR_W-1:0]        core_address;
    logic [DATA_W-1:0]        core_write_data;
    logic [NUM_CH*DATA_W-1:0] core_read_data;
    logic [NUM_CH-1:0]        core_error;

    modport slave (
        input  pio_write, pio_address, pio_control,
        input  core_read_data, core_error,
        output pio_read, pio_status,
        output core_cs, core_we, core_address, core_write_data
    );

    modport master (
        output pio_write, pio_address, pio_control,
        output core_read_data, core_error,
        input  pio_read, pio_status,
        input  core_cs, core_we, core_address, core_write_data
    );
endinterface

// File: rtl/sha_pio_bridge.sv
// Four-phase PIO request bridge: one single-cycle strobe to the selected hash core
// per CPU request edge, with registered ack/busy/error status and read capture.
module sha_pio_bridge #(
    parameter int NUM_CH   = 4,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input logic             clk,
    input logic             reset_n,
    sha_pio_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam bit          LAT0   = (READ_LAT == 0);
    localparam logic [3:0]  LAT_M1 = (READ_LAT > 0) ? 4'(READ_LAT - 1) : 4'd0;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                we_q, we_d;
    logic [5:0]          ch_q, ch_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [NUM_CH-1:0]   cs_q, cs_d;
    logic [NUM_CH-1:0]   wen_q, wen_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                bad_q, bad_d;
    logic                err_q, err_d;

    logic                req_in;
    logic                edge_in;
    logic [5:0]          ch_in;
    logic                ch_ok;
    logic [DATA_W-1:0]   rd_sel;

    assign req_in  = bus.pio_control[0];
    assign ch_in   = bus.pio_control[7:2];
    assign edge_in = req_in & ~req_q;
    assign ch_ok   = {1'b0, ch_in} < 7'(NUM_CH);

    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_q == 6'(k)) begin
                rd_sel = bus.core_read_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_in;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        cs_d    = '0;
        wen_d   = '0;
        ack_d   = ack_q;
        busy_d  = busy_q;
        bad_d   = bad_q;
        err_d   = |bus.core_error;
        unique case (state_q)
            S_IDLE: begin
                if (edge_in) begin
                    addr_d  = bus.pio_address;
                    wdata_d = bus.pio_write;
                    we_d    = bus.pio_control[1];
                    ch_d    = ch_in;
                    if (ch_ok) begin
                        bad_d   = 1'b0;
                        busy_d  = 1'b1;
                        cs_d    = NUM_CH'(1) << ch_in;
                        wen_d   = bus.pio_control[1] ? cs_d : '0;
                        state_d = S_ISSUE;
                    end else begin
                        // Out-of-range channel: report without touching any core.
                        bad_d   = 1'b1;
                        ack_d   = 1'b1;
                        state_d = S_ACK;
                    end
                end
            end
            S_ISSUE: begin
                if (we_q || LAT0) begin
                    if (!we_q) begin
                        rdata_d = rd_sel;
                    end
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = rd_sel;
                    busy_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (!req_in) begin
                    ack_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            ch_q    <= '0;
            cnt_q   <= '0;
            cs_q    <= '0;
            wen_q   <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            wen_q   <= wen_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    assign bus.pio_read        = rdata_q;
    assign bus.pio_status      = {4'b0000, err_q, bad_q, busy_q, ack_q};
    assign bus.core_cs         = cs_q;
    assign bus.core_we         = wen_q;
    assign bus.core_address    = addr_q;
    assign bus.core_write_data = wdata_q;
endmodule

// File: tb/tb_sha_pio_bridge.sv
// Bench for sha_pio_bridge: READ_LAT=1 and READ_LAT=3 instances, each backed by a
// behavioural core array, checked against a transaction-level reference model.
module tb_sha_pio_bridge;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    sha_pio_bridge_if #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32)) ifa ();
    sha_pio_bridge_if #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32)) ifb ();

    sha_pio_bridge #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .READ_LAT(1)) dut_a (
        .clk(clk), .reset_n(rst_a), .bus(ifa)
    );
    sha_pio_bridge #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32), .READ_LAT(3)) dut_b (
        .clk(clk), .reset_n(rst_b), .bus(ifb)
    );

    // Behavioural cores: storage plus read data that is valid only LAT cycles after cs.
    logic [31:0] mem     [2][1024];
    logic [31:0] ref_mem [2][1024];
    logic [31:0] model_rd [2];
    int age    [2] = '{100, 100};
    int cch    [2] = '{0, 0};
    int cad    [2] = '{0, 0};
    int pulses [2] = '{0, 0};
    int viol   [2] = '{0, 0};

    function automatic logic [127:0] core_cycle(input int id, input int lat,
                                                input logic [3:0] cs, input logic [3:0] we,
                                                input logic [7:0] ad, input logic [31:0] wd);
        logic [127:0] rd;
        if ((we & ~cs) != 4'd0) viol[id]++;
        if (cs != 4'd0) begin
            if (!$onehot(cs)) viol[id]++;
            pulses[id]++;
            age[id] = 0;
            for (int k = 0; k < 4; k++) if (cs[k]) cch[id] = k;
            cad[id] = int'(ad);
            if (we != 4'd0) mem[id][cch[id]*256 + int'(ad)] = wd;
        end else if (age[id] < 100) begin
            age[id]++;
        end
        for (int k = 0; k < 4; k++) begin
            if (age[id] == lat && k == cch[id]) rd[k*32 +: 32] = mem[id][cch[id]*256 + cad[id]];
            else rd[k*32 +: 32] = $urandom;
        end
        return rd;
    endfunction

    always @(negedge clk)
        ifa.core_read_data = core_cycle(0, 1, ifa.core_cs, ifa.core_we, ifa.core_address, ifa.core_write_data);
    always @(negedge clk)
        ifb.core_read_data = core_cycle(1, 3, ifb.core_cs, ifb.core_we, ifb.core_address, ifb.core_write_data);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        ifa.pio_write = '0; ifa.pio_address = '0; ifa.pio_control = '0; ifa.core_error = '0;
        ifb.pio_write = '0; ifb.pio_address = '0; ifb.pio_control = '0; ifb.core_error = '0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        repeat (3) step();
        tests_run++;
        if ({ifa.pio_read, ifa.pio_status, ifa.core_cs, ifa.core_we, ifa.core_address, ifa.core_write_data} !== '0) begin
            tests_failed++;
            $display("FAIL reset_a: got read=%h status=%h cs=%b we=%b addr=%h wd=%h want all 0",
                     ifa.pio_read, ifa.pio_status, ifa.core_cs, ifa.core_we, ifa.core_address, ifa.core_write_data);
        end
        tests_run++;
        if ({ifb.pio_read, ifb.pio_status, ifb.core_cs, ifb.core_we} !== '0) begin
            tests_failed++;
            $display("FAIL reset_b: got read=%h status=%h cs=%b we=%b want all 0",
                     ifb.pio_read, ifb.pio_status, ifb.core_cs, ifb.core_we);
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) step();
    endtask

    // One CPU transaction on the READ_LAT=1 instance, checked against the reference model.
    task automatic run_txn_a(input int ch, input bit we, input logic [7:0] ad,
                             input logic [31:0] wd, input bit drop, input int hold);
        int n;
        int p0;
        int exp_lat;
        bit bad;
        logic [3:0] exp_cs;
        bad = (ch >= 4);
        exp_lat = bad ? 1 : (we ? 2 : 3);
        exp_cs = bad ? 4'd0 : 4'(1 << ch);
        if (!bad && !we) model_rd[0] = ref_mem[0][ch*256 + int'(ad)];
        if (!bad && we) ref_mem[0][ch*256 + int'(ad)] = wd;
        p0 = pulses[0];
        ifa.pio_address = ad;
        ifa.pio_write = wd;
        ifa.pio_control = {6'(ch), we, 1'b1};
        n = 0;
        do begin
            step();
            n++;
            if (n == 1) begin
                if (!bad) begin
                    tests_run++;
                    if ({ifa.core_cs, ifa.core_we, ifa.core_address, ifa.core_write_data, ifa.pio_status[1]}
                        !== {exp_cs, (we ? exp_cs : 4'd0), ad, wd, 1'b1}) begin
                        tests_failed++;
                        $display("FAIL issue ch%0d we%0d: got cs=%b we=%b addr=%h wd=%h busy=%b want cs=%b addr=%h wd=%h busy=1",
                                 ch, we, ifa.core_cs, ifa.core_we, ifa.core_address, ifa.core_write_data,
                                 ifa.pio_status[1], exp_cs, ad, wd);
                    end
                end
                ifa.pio_address = $urandom;
                ifa.pio_write = $urandom;
                ifa.pio_control = {6'($urandom), 1'($urandom), ~drop};
            end
        end while (ifa.pio_status[0] !== 1'b1 && n < 12);
        tests_run++;
        if (n != exp_lat) begin
            tests_failed++;
            $display("FAIL ack_latency ch%0d we%0d: got %0d cycles want %0d", ch, we, n, exp_lat);
        end
        tests_run++;
        if ({ifa.pio_read, ifa.pio_status[2:1]} !== {model_rd[0], bad, 1'b0}) begin
            tests_failed++;
            $display("FAIL ack_state ch%0d we%0d: got read=%h bad=%b busy=%b want read=%h bad=%b busy=0",
                     ch, we, ifa.pio_read, ifa.pio_status[2], ifa.pio_status[1], model_rd[0], bad);
        end
        if (!drop && hold > 0) begin
            repeat (hold) step();
            tests_run++;
            if (ifa.pio_status[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL ack_hold: got ack=%b after %0d held cycles want 1", ifa.pio_status[0], hold);
            end
        end
        ifa.pio_control[0] = 1'b0;
        step();
        tests_run++;
        if (ifa.pio_status[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ack_clear: got ack=%b want 0", ifa.pio_status[0]);
        end
        tests_run++;
        if (pulses[0] - p0 != (bad ? 0 : 1)) begin
            tests_failed++;
            $display("FAIL cs_pulses ch%0d: got %0d want %0d", ch, pulses[0] - p0, bad ? 0 : 1);
        end
    endtask

    task automatic test_write();
        run_txn_a(2, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 0);
    endtask

    task automatic test_read();
        run_txn_a(1, 1'b1, 8'h20, 32'h12345678, 1'b0, 0);
        run_txn_a(1, 1'b0, 8'h20, 32'h0, 1'b0, 0);
        tests_run++;
        if (ifa.pio_read !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL read_value: got %h want 12345678", ifa.pio_read);
        end
        run_txn_a(0, 1'b1, 8'h33, 32'hCAFEF00D, 1'b0, 0);
        tests_run++;
        if (ifa.pio_read !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL read_hold: got %h want 12345678", ifa.pio_read);
        end
    endtask

    task automatic test_bad_ch();
        run_txn_a(5, 1'b0, 8'h44, 32'h0, 1'b0, 2);
        run_txn_a(0, 1'b1, 8'h45, 32'h0BADF00D, 1'b0, 0);
    endtask

    task automatic test_hold();
        run_txn_a(3, 1'b1, 8'h50, 32'h01020304, 1'b0, 20);
        run_txn_a(3, 1'b0, 8'h50, 32'h0, 1'b0, 0);
    endtask

    task automatic test_core_err();
        ref_mem[0][3*256 + 8'h60] = 32'hA5A5A5A5;
        ifa.pio_address = 8'h60;
        ifa.pio_write = 32'hA5A5A5A5;
        ifa.pio_control = 8'h0F;
        ifa.core_error = 4'b1000;
        step();
        tests_run++;
        if ({ifa.pio_status[3], ifa.core_cs} !== {1'b1, 4'b1000}) begin
            tests_failed++;
            $display("FAIL core_err_set: got err=%b cs=%b want err=1 cs=1000", ifa.pio_status[3], ifa.core_cs);
        end
        ifa.core_error = 4'b0000;
        step();
        tests_run++;
        if (ifa.pio_status[3:0] !== 4'b0001) begin
            tests_failed++;
            $display("FAIL core_err_clear: got status=%b want 0001", ifa.pio_status[3:0]);
        end
        ifa.pio_control = 8'h00;
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn_a(int'($urandom_range(0, 5)), 1'($urandom), 8'($urandom), $urandom,
                      ($urandom_range(0, 2) == 0), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) step();
        end
    endtask

    // READ_LAT=3 read; a req drop and re-raise while busy must not spawn a second access.
    task automatic test_lat3();
        int n;
        int p0;
        int ch;
        logic [7:0] ad;
        ch = int'($urandom_range(0, 3));
        ad = 8'($urandom);
        model_rd[1] = ref_mem[1][ch*256 + int'(ad)];
        p0 = pulses[1];
        ifb.pio_address = ad;
        ifb.pio_control = {6'(ch), 2'b01};
        n = 0;
        do begin
            step();
            n++;
            if (n == 2) ifb.pio_control[0] = 1'b0;
            if (n == 3) ifb.pio_control[0] = 1'b1;
        end while (ifb.pio_status[0] !== 1'b1 && n < 12);
        tests_run++;
        if (n != 5 || ifb.pio_read !== model_rd[1]) begin
            tests_failed++;
            $display("FAIL lat3_read: got %0d cycles read=%h want 5 cycles read=%h", n, ifb.pio_read, model_rd[1]);
        end
        repeat (3) step();
        ifb.pio_control[0] = 1'b0;
        repeat (4) step();
        tests_run++;
        if (pulses[1] - p0 != 1 || ifb.pio_status[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL lat3_single: got %0d pulses ack=%b want 1 pulse ack=0", pulses[1] - p0, ifb.pio_status[0]);
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        ifb.pio_address = 8'h77;
        ifb.pio_control = 8'h05;
        step();
        tests_run++;
        if (ifb.core_cs !== 4'b0010) begin
            tests_failed++;
            $display("FAIL mid_cs: got %b want 0010", ifb.core_cs);
        end
        step();
        #1 rst_b = 1'b0;
        #1;
        model_rd[1] = '0;
        tests_run++;
        if ({ifb.pio_read, ifb.pio_status, ifb.core_cs, ifb.core_we, ifb.core_address} !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset: got read=%h status=%h cs=%b we=%b addr=%h want all 0",
                     ifb.pio_read, ifb.pio_status, ifb.core_cs, ifb.core_we, ifb.core_address);
        end
        ifb.pio_control = 8'h00;
        step();
        rst_b = 1'b1;
        p0 = pulses[1];
        repeat (6) step();
        tests_run++;
        if (pulses[1] != p0 || ifb.pio_status !== 8'h00) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got %0d pulses status=%h want 0 pulses status=00",
                     pulses[1] - p0, ifb.pio_status);
        end
        test_lat3();
    endtask

    task automatic test_invariants();
        tests_run++;
        if (viol[0] != 0 || viol[1] != 0) begin
            tests_failed++;
            $display("FAIL cs_onehot: got %0d/%0d violations want 0/0", viol[0], viol[1]);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 1024; j++) begin
                mem[i][j] = $urandom;
                ref_mem[i][j] = mem[i][j];
            end
        end
        test_reset();
        test_write();
        test_read();
        test_bad_ch();
        test_hold();
        test_core_err();
        test_random();
        test_lat3();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
